if_id_fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register for the 16-bit, 8-register pipelined core.
- Owns the PC and issues requests to instruction memory over a variable-latency req/ack handshake.
- Presents fetched instructions to the decode stage (register file read, extender) with valid, PC and PC+1.
- Honours stall from the hazard unit and redirect/flush from branch/jump resolution; a 1-entry skid buffer absorbs a returning fetch while decode is stalled.

---
 rtl/if_id_fetch_stage_if.sv | 15 +
 rtl/if_id_fetch_stage.sv | 138 +++++++++++++
 tb/tb_if_id_fetch_stage.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/if_id_fetch_stage_if.sv
// Instruction-memory request/response bus used by the fetch stage.
//   imem_req   : fetch request, driven by the fetch stage
//   imem_addr  : fetch address, held stable while a request is pending
//   imem_ack   : one-cycle completion pulse from memory (may come in the request cycle)
//   imem_rdata : instruction word, valid in the ack cycle
// Modports: master = fetch stage, slave = instruction memory.
interface if_id_fetch_stage_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 16-bit core.
// Owns the PC, fetches over a variable-latency req/ack bus, and presents
// fetched words to decode. A one-entry skid buffer catches a fetch that
// returns while decode is stalled. A redirect flushes IF/ID and retargets the
// PC; if a fetch is still in flight, its response is drained and discarded.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   stall           : hold IF/ID, nothing new enters decode
//   redirect        : taken branch/jump, flush IF/ID and load redirect_pc
//   redirect_pc     : branch/jump target
//   imem            : instruction-memory bus (master side)
//   id_valid        : IF/ID holds a live instruction
//   id_instr        : instruction to decode (zero when flushed/reset)
//   id_pc           : PC of id_instr
//   id_pc_plus1     : id_pc + PC_INC, feeds the branch-target adder
module if_id_fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_INC   = 16'h0001
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       redirect,
  input  logic [15:0]                redirect_pc,
  if_id_fetch_stage_if.master        imem,
  output logic                       id_valid,
  output logic [15:0]                id_instr,
  output logic [15:0]                id_pc,
  output logic [15:0]                id_pc_plus1
);

  // FETCH: request pc. HOLD: skid full, waiting for decode, no request.
  // DROP: a pre-redirect request is still in flight; wait for and discard it.
  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  typedef struct packed {
    logic        valid;
    logic [15:0] instr;
    logic [15:0] pc;
  } skid_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] req_addr_q, req_addr_d;
  skid_t       skid_q, skid_d;
  logic        id_valid_d;
  logic [15:0] id_instr_d, id_pc_d, id_pc_plus1_d;

  // Bus outputs decoded from state; req_addr only moves when no request is
  // pending, so the address is stable until the ack.
  assign imem.imem_req  = !rst && (state_q != HOLD);
  assign imem.imem_addr = req_addr_q;

  // NOTE: every variable gets its hold value first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    skid_d        = skid_q;
    id_valid_d    = id_valid;
    id_instr_d    = id_instr;
    id_pc_d       = id_pc;
    id_pc_plus1_d = id_pc_plus1;

    if (redirect) begin
      // Redirect beats stall and ack. An unacked request must still complete,
      // so FETCH/DROP without ack park in DROP; HOLD has nothing in flight.
      pc_d       = redirect_pc;
      id_valid_d = 1'b0;
      id_instr_d = 16'h0000;
      skid_d     = '0;
      state_d    = (state_q != HOLD && !imem.imem_ack) ? DROP : FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (imem.imem_ack) begin
            pc_d = pc_q + PC_INC;
            if (stall) begin
              skid_d  = '{valid: 1'b1, instr: imem.imem_rdata, pc: pc_q};
              state_d = HOLD;
            end else begin
              id_valid_d    = 1'b1;
              id_instr_d    = imem.imem_rdata;
              id_pc_d       = pc_q;
              id_pc_plus1_d = pc_q + PC_INC;
            end
          end else if (!stall) begin
            // Bubble: data fields hold, only valid drops.
            id_valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            id_valid_d    = skid_q.valid;
            id_instr_d    = skid_q.instr;
            id_pc_d       = skid_q.pc;
            id_pc_plus1_d = skid_q.pc + PC_INC;
            skid_d        = '0;
            state_d       = FETCH;
          end
        end
        DROP: begin
          if (imem.imem_ack) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end

    // Entering or staying in FETCH always requests pc; in DROP the old
    // address must stay on the bus until its ack.
    req_addr_d = (state_d == DROP) ? req_addr_q : pc_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      skid_q      <= '0;
      id_valid    <= 1'b0;
      id_instr    <= 16'h0000;
      id_pc       <= 16'h0000;
      id_pc_plus1 <= 16'h0000;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      skid_q      <= skid_d;
      id_valid    <= id_valid_d;
      id_instr    <= id_instr_d;
      id_pc       <= id_pc_d;
      id_pc_plus1 <= id_pc_plus1_d;
    end
  end

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Directed bench for if_id_fetch_stage: a queue-based behavioural model is
// compared against the DUT on every falling edge, and literal expectations at
// key points pin the model itself.
module tb_if_id_fetch_stage;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] PC_INC   = 16'h0001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        tie = 1'b1;      // ack follows req combinationally
  logic        ack_drv = 1'b0;  // ack when not tied
  logic        id_valid;
  logic [15:0] id_instr, id_pc, id_pc_plus1;

  int n_checks = 0;
  int n_fail   = 0;

  if_id_fetch_stage_if bus ();

  assign bus.imem_ack   = tie ? bus.imem_req : ack_drv;
  assign bus.imem_rdata = 16'hA000 | bus.imem_addr;

  if_id_fetch_stage #(.RESET_PC(RESET_PC), .PC_INC(PC_INC)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus.master),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc_plus1 (id_pc_plus1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
  } ent_t;

  logic [15:0] m_pc, m_old_addr;
  bit          m_drop;          // a pre-redirect request is still in flight
  ent_t        m_skid[$];       // fetched word waiting for decode to unstall
  logic        m_valid;
  logic [15:0] m_instr, m_idpc, m_idpc1;

  // Inputs sampled mid-cycle, applied at the next rising edge.
  logic        s_ack, s_stall, s_redirect;
  logic [15:0] s_rdata, s_rpc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = RESET_PC; m_drop = 0; m_old_addr = RESET_PC;
      m_skid.delete();
      m_valid = 0; m_instr = 0; m_idpc = 0; m_idpc1 = 0;
    end else begin
      bit requesting;
      requesting = (m_skid.size() == 0);
      if (s_redirect) begin
        if (requesting && !s_ack && !m_drop) begin
          m_drop = 1; m_old_addr = m_pc;
        end else if (requesting && s_ack) begin
          m_drop = 0;
        end
        m_skid.delete();
        m_pc = s_rpc;
        m_valid = 0; m_instr = 0;
      end else if (!requesting) begin
        if (!s_stall) begin
          m_valid = 1; m_instr = m_skid[0].instr;
          m_idpc = m_skid[0].pc; m_idpc1 = m_skid[0].pc + PC_INC;
          m_skid.delete();
        end
      end else if (m_drop) begin
        if (s_ack) m_drop = 0;
      end else if (s_ack) begin
        if (s_stall) m_skid.push_back('{instr: s_rdata, pc: m_pc});
        else begin
          m_valid = 1; m_instr = s_rdata; m_idpc = m_pc; m_idpc1 = m_pc + PC_INC;
        end
        m_pc = m_pc + PC_INC;
      end else if (!s_stall) begin
        m_valid = 0;
      end
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    logic exp_req;
    exp_req = !rst && (m_skid.size() == 0);
    check("cmp imem_req", {15'd0, bus.imem_req}, {15'd0, exp_req});
    if (exp_req) check("cmp imem_addr", bus.imem_addr, m_drop ? m_old_addr : m_pc);
    check("cmp id_valid", {15'd0, id_valid}, {15'd0, m_valid});
    check("cmp id_instr", id_instr, m_instr);
    check("cmp id_pc", id_pc, m_idpc);
    check("cmp id_pc_plus1", id_pc_plus1, m_idpc1);
    s_ack = bus.imem_ack; s_rdata = bus.imem_rdata;
    s_stall = stall; s_redirect = redirect; s_rpc = redirect_pc;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    #1 rst = 1'b1;
    #1;
    check("reset req", {15'd0, bus.imem_req}, 16'd0);
    check("reset id_valid", {15'd0, id_valid}, 16'd0);
    check("reset id_instr", id_instr, 16'h0000);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("stream first req", {15'd0, bus.imem_req}, 16'd1);
    check("stream first addr", bus.imem_addr, 16'h0000);

    // Streaming with ack tied to req.
    tick();
    check("stream instr0", id_instr, 16'hA000);
    check("stream pc0", id_pc, 16'h0000);
    check("stream pc0+1", id_pc_plus1, 16'h0001);
    check("stream addr1", bus.imem_addr, 16'h0001);
    tick(); tick(); tick();
    check("stream instr3", id_instr, 16'hA003);
    check("stream addr4", bus.imem_addr, 16'h0004);

    // Stall for 3 cycles while addr 4 returns into the skid.
    stall = 1'b1;
    tick();
    check("hold req", {15'd0, bus.imem_req}, 16'd0);
    check("hold instr", id_instr, 16'hA003);
    tick(); tick();
    check("hold instr late", id_instr, 16'hA003);
    stall = 1'b0;
    tick();
    check("skid instr", id_instr, 16'hA004);
    check("skid pc", id_pc, 16'h0004);
    check("resume addr", bus.imem_addr, 16'h0005);
    tick();
    check("addr6", bus.imem_addr, 16'h0006);

    // Redirect while addr 6 is outstanding; ack comes 3 cycles later.
    tie = 1'b0; ack_drv = 1'b0;
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    check("drop addr held", bus.imem_addr, 16'h0006);
    check("drop flushed", {15'd0, id_valid}, 16'd0);
    check("drop instr zero", id_instr, 16'h0000);
    tick();
    check("drop addr held 2", bus.imem_addr, 16'h0006);
    tick();
    ack_drv = 1'b1;
    tick();
    ack_drv = 1'b0;
    check("post drop addr", bus.imem_addr, 16'h0040);
    check("post drop valid", {15'd0, id_valid}, 16'd0);

    // Redirect and stall together while the skid is full.
    tie = 1'b1;
    tick();
    check("instr 40", id_instr, 16'hA040);
    stall = 1'b1;
    tick();
    redirect = 1'b1; redirect_pc = 16'h0100;
    tick();
    redirect = 1'b0; stall = 1'b0;
    check("rs flushed", {15'd0, id_valid}, 16'd0);
    check("rs instr zero", id_instr, 16'h0000);
    check("rs addr", bus.imem_addr, 16'h0100);
    tick();
    check("rs skid dropped", id_instr, 16'hA100);
    check("rs pc", id_pc, 16'h0100);

    // Wrap-around.
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    tick();
    redirect = 1'b0;
    check("wrap addr", bus.imem_addr, 16'hFFFF);
    tick();
    check("wrap pc", id_pc, 16'hFFFF);
    check("wrap pc+1", id_pc_plus1, 16'h0000);
    check("wrap next addr", bus.imem_addr, 16'h0000);
    tick();
    check("wrap next pc", id_pc, 16'h0000);
    check("wrap next instr", id_instr, 16'hA000);

    // Async reset while a redirected fetch is being drained.
    tie = 1'b0; ack_drv = 1'b0;
    redirect = 1'b1; redirect_pc = 16'h0200;
    tick();
    redirect = 1'b0;
    check("pre-reset drop addr", bus.imem_addr, 16'h0001);
    #2 rst = 1'b1;
    #1;
    check("async req", {15'd0, bus.imem_req}, 16'd0);
    check("async id_valid", {15'd0, id_valid}, 16'd0);
    check("async id_instr", id_instr, 16'h0000);
    check("async id_pc", id_pc, 16'h0000);
    check("async id_pc_plus1", id_pc_plus1, 16'h0000);
    tick(); tick();
    tie = 1'b1;
    rst = 1'b0;
    #1;
    check("after reset req", {15'd0, bus.imem_req}, 16'd1);
    check("after reset addr", bus.imem_addr, RESET_PC);
    tick();
    check("after reset instr", id_instr, 16'hA000);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
